rx_ipv4: RTL
============

// Module: rx_ipv4
// PURPOSE
//  Receive-side IPv4 stage between the Ethernet receive stage and rx_udp.
//  - Parses the IPv4 header from the Ethernet payload byte stream.
//  - Validates the header; drops failing packets.
//  - Strips the header and any options; forwards only the IP payload.
//  - Output feeds rx_udp, which expects data_v to rise exactly on the first payload byte.
// PARAMETERS
//  OCT        8      byte width
//  PROTO      8'h11  accepted protocol number (UDP)
// PORTS
//  RX_CLK          in   1      receive clock; the only clock
//  rst             in   1      synchronous, active-high reset
//  func_en         in   1      0: all state and outputs hold; rst still wins
//  ip_addr         in   32     local IPv4 address
//  rx_ether_irq    in   1      end-of-frame pulse from upstream (unused for timing)
//  rx_ether_data_v in   1      high while the Ethernet payload is valid; one byte per cycle
//  rx_ether_data   in   OCT    payload byte, network order
//  rx_src_ip       out  32     source IP of the last accepted packet
//  rx_ipv4_irq     out  1      1-cycle pulse at the end of an accepted packet
//  rx_ipv4_data_v  out  1      payload valid, contiguous per packet
//  rx_ipv4_data    out  OCT    payload byte
// BEHAVIOUR
//  Reset: state=IDLE; counters=0; rx_ipv4_data_v=0; rx_ipv4_irq=0; rx_ipv4_data=0; rx_src_ip=0.
//  States: IDLE, HEADER, OPTIONS, PAYLOAD, DROP.
//  - IDLE -> HEADER on the rising edge of rx_ether_data_v. That first byte is header byte 0.
//  - HEADER captures bytes 0..19:
//    - ver/IHL (byte 0); total_len (bytes 2-3); flags/frag (bytes 6-7)
//    - proto (byte 9); src (bytes 12-15); dst (bytes 16-19)
//  - Checksum: 17-bit ones-complement accumulator over 16-bit words; end-around carry added each word.
//  - After byte 19, the packet is accepted only if all hold:
//    - ver==4 and IHL>=5
//    - MF==0 and frag_off==0
//    - proto==PROTO
//    - dst==ip_addr or dst==32'hFFFFFFFF
//    - total_len >= IHL*4
//  - On accept, go to OPTIONS if IHL>5, else PAYLOAD. On reject, go to DROP.
//  - OPTIONS consumes (IHL-5)*4 bytes into the checksum.
//    - Final sum != 16'hFFFF -> DROP.
//    - Otherwise -> PAYLOAD.
//  - For IHL==5 the checksum test is made at byte 19, together with the other checks.
//  - PAYLOAD forwards exactly total_len - IHL*4 bytes.
//    - Latency: 1 cycle, with rx_ipv4_data_v registered alongside the data.
//    - Trailing Ethernet padding is suppressed (data_v=0).
//    - On the last payload byte: rx_ipv4_irq=1 on the following cycle; rx_src_ip updates; go to DROP (swallows padding).
//  - Payload length 0: no data_v. irq still pulses one cycle after the last header byte.
//  - DROP -> IDLE when rx_ether_data_v==0.
//  - rx_ether_data_v falls early:
//    - In HEADER or OPTIONS: go to IDLE; no irq; no output.
//    - In PAYLOAD: data_v drops, no irq, go to IDLE. rx_udp then sees a truncated frame.
//  - data_v stays high across a new frame with no gap: undefined. Upstream guarantees >=1 idle cycle.
//  - Widths: byte counter and length arithmetic are 16 bit. IHL*4 is formed as {IHL,2'b00}, zero-extended.
// STRUCTURE
//  - Shared package/header `ipv4_defs.vh`: state encodings, header byte offsets,
//    IPV4_VER=4, IPV4_IHL_MIN=5, PROTO_UDP=8'h11, PROTO_ICMP=8'h01, IP_BCAST.
//  - One sub-module: ipv4_csum16.
//    - Pairs bytes into 16-bit words and accumulates with end-around carry.
//    - Ports: clear, byte_v, byte, sum[15:0].
// TESTING
//  1. 20-byte header (checksum valid), dst=ip_addr, proto 0x11, total_len=28, 8 payload bytes
//     -> 8 data_v bytes matching input; irq 1 cycle after the last byte; rx_src_ip = header src.
//  2. Same packet, checksum byte flipped -> no data_v, no irq; next good packet accepted.
//  3. IHL=6 (4 option bytes), total_len=32 -> options stripped, 8 payload bytes out.
//  4. total_len=28 in a 46-byte Ethernet payload (padding)
//     -> exactly 8 bytes out; padding suppressed; DROP -> IDLE at data_v fall.
//  5. Each single reject: dst mismatch; proto 0x06; MF=1; ver=6 -> no output.
//     Broadcast dst 255.255.255.255 -> accepted.
//  6. Two cases:
//     - rx_ether_data_v drops at header byte 10 -> IDLE, no irq.
//     - rst pulsed mid-payload -> outputs 0 next cycle; next packet parsed correctly.

Source files
------------

// File: rtl/rx_ipv4_pkg.sv
// Shared definitions for the receive-side IPv4 stage: state encoding,
// header byte offsets and protocol constants.
package rx_ipv4_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_OPTIONS = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DROP    = 3'd4
    } state_t;

    localparam logic [3:0]  IPV4_VER     = 4'd4;
    localparam logic [3:0]  IPV4_IHL_MIN = 4'd5;
    localparam logic [7:0]  PROTO_UDP    = 8'h11;
    localparam logic [7:0]  PROTO_ICMP   = 8'h01;
    localparam logic [31:0] IP_BCAST     = 32'hFFFF_FFFF;
    localparam logic [15:0] CSUM_OK      = 16'hFFFF;

    localparam logic [15:0] OFF_VER_IHL = 16'd0;
    localparam logic [15:0] OFF_LEN_HI  = 16'd2;
    localparam logic [15:0] OFF_LEN_LO  = 16'd3;
    localparam logic [15:0] OFF_FRAG_HI = 16'd6;
    localparam logic [15:0] OFF_FRAG_LO = 16'd7;
    localparam logic [15:0] OFF_PROTO   = 16'd9;
    localparam logic [15:0] OFF_SRC0    = 16'd12;
    localparam logic [15:0] OFF_SRC3    = 16'd15;
    localparam logic [15:0] OFF_DST0    = 16'd16;
    localparam logic [15:0] OFF_DST3    = 16'd19;

    function automatic logic [15:0] ihl_bytes(input logic [3:0] ihl);
        return {10'd0, ihl, 2'b00};
    endfunction

endpackage

// File: rtl/ipv4_csum16.sv
// Ones-complement header checksum: pairs bytes into big-endian 16-bit words.
// sum reflects the running total including the byte presented this cycle.
module ipv4_csum16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_v,
    input  logic [7:0]  byte_dat,
    output logic [15:0] sum
);

    logic [15:0] acc_q, acc_d, base_acc;
    logic [7:0]  hi_q, hi_d;
    logic        odd_q, odd_d, base_odd;
    logic [16:0] add;

    // clear restarts the sum so the byte arriving with it becomes the first
    always_comb begin
        base_acc = clear ? 16'd0 : acc_q;
        base_odd = clear ? 1'b0 : odd_q;
        acc_d    = base_acc;
        hi_d     = hi_q;
        odd_d    = base_odd;
        add      = 17'd0;
        if (byte_v) begin
            if (base_odd) begin
                add   = {1'b0, base_acc} + {1'b0, hi_q, byte_dat};
                acc_d = add[15:0] + {15'd0, add[16]};
                odd_d = 1'b0;
            end else begin
                hi_d  = byte_dat;
                odd_d = 1'b1;
            end
        end
    end

    assign sum = acc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= 16'd0;
            hi_q  <= 8'd0;
            odd_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            hi_q  <= hi_d;
            odd_q <= odd_d;
        end
    end

endmodule

// File: rtl/rx_ipv4.sv
// IPv4 receive stage: parses and validates the header, strips header/options
// and forwards only the IP payload one cycle later; failing packets are dropped.
module rx_ipv4
    import rx_ipv4_pkg::*;
#(
    parameter int         OCT   = 8,
    parameter logic [7:0] PROTO = PROTO_UDP
) (
    input  logic           RX_CLK,
    input  logic           rst,
    input  logic           func_en,
    input  logic [31:0]    ip_addr,
    input  logic           rx_ether_irq,
    input  logic           rx_ether_data_v,
    input  logic [OCT-1:0] rx_ether_data,
    output logic [31:0]    rx_src_ip,
    output logic           rx_ipv4_irq,
    output logic           rx_ipv4_data_v,
    output logic [OCT-1:0] rx_ipv4_data
);

    state_t          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d, pay_left_q, pay_left_d;
    logic [7:0]      vihl_q, vihl_d, proto_q, proto_d;
    logic [15:0]     tl_q, tl_d, frag_q, frag_d;
    logic [31:0]     src_q, src_d, src_ip_q, src_ip_d;
    logic [23:0]     dst_q, dst_d;
    logic            prev_q, prev_d;
    logic            data_v_q, data_v_d, irq_q, irq_d;
    logic [OCT-1:0]  data_q, data_d;

    logic [15:0]     ihl4, pay_len, hdr_last, idx, csum_sum;
    logic [31:0]     dst_full;
    logic            hdr_ok, hdr_byte, hdr_done, csum_clr, csum_v;
    logic            unused_ether_irq;

    assign unused_ether_irq = rx_ether_irq;

    assign ihl4     = ihl_bytes(vihl_q[3:0]);
    assign pay_len  = tl_q - ihl4;
    assign hdr_last = ihl4 - 16'd1;
    assign dst_full = {dst_q, rx_ether_data};
    assign hdr_ok   = (vihl_q[7:4] == IPV4_VER) && (vihl_q[3:0] >= IPV4_IHL_MIN)
                   && !frag_q[13] && (frag_q[12:0] == 13'd0)
                   && (proto_q == PROTO)
                   && ((dst_full == ip_addr) || (dst_full == IP_BCAST))
                   && (tl_q >= ihl4);

    assign csum_clr = func_en && (state_q == ST_IDLE);
    assign csum_v   = func_en && rx_ether_data_v
                   && (state_q == ST_IDLE || state_q == ST_HEADER || state_q == ST_OPTIONS);

    ipv4_csum16 u_csum (
        .clk      (RX_CLK),
        .rst      (rst),
        .clear    (csum_clr),
        .byte_v   (csum_v),
        .byte_dat (rx_ether_data[7:0]),
        .sum      (csum_sum)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pay_left_d = pay_left_q;
        vihl_d     = vihl_q;
        tl_d       = tl_q;
        frag_d     = frag_q;
        proto_d    = proto_q;
        src_d      = src_q;
        dst_d      = dst_q;
        prev_d     = rx_ether_data_v;
        data_d     = data_q;
        data_v_d   = 1'b0;
        irq_d      = 1'b0;
        src_ip_d   = src_ip_q;
        hdr_byte   = 1'b0;
        hdr_done   = 1'b0;
        idx        = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (rx_ether_data_v && !prev_q) begin
                    state_d  = ST_HEADER;
                    idx      = 16'd0;
                    hdr_byte = 1'b1;
                end
            end
            ST_HEADER: begin
                if (!rx_ether_data_v) state_d = ST_IDLE;
                else                  hdr_byte = 1'b1;
            end
            ST_OPTIONS: begin
                if (!rx_ether_data_v) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == hdr_last) begin
                        if (csum_sum == CSUM_OK) hdr_done = 1'b1;
                        else                     state_d  = ST_DROP;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!rx_ether_data_v) begin
                    state_d = ST_IDLE;
                end else begin
                    data_d     = rx_ether_data;
                    data_v_d   = 1'b1;
                    pay_left_d = pay_left_q - 16'd1;
                    if (pay_left_q == 16'd1) begin
                        irq_d    = 1'b1;
                        src_ip_d = src_q;
                        state_d  = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (!rx_ether_data_v) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (hdr_byte) begin
            cnt_d = idx + 16'd1;
            case (idx)
                OFF_VER_IHL:             vihl_d  = rx_ether_data;
                OFF_LEN_HI, OFF_LEN_LO:  tl_d    = {tl_q[7:0], rx_ether_data};
                OFF_FRAG_HI, OFF_FRAG_LO: frag_d = {frag_q[7:0], rx_ether_data};
                OFF_PROTO:               proto_d = rx_ether_data;
                default: ;
            endcase
            if (idx >= OFF_SRC0 && idx <= OFF_SRC3) src_d = {src_q[23:0], rx_ether_data};
            if (idx >= OFF_DST0 && idx <  OFF_DST3) dst_d = {dst_q[15:0], rx_ether_data};
            // Basic header checks are settled on the last fixed byte; the
            // checksum waits for the options when there are any.
            if (idx == OFF_DST3) begin
                if (!hdr_ok)                          state_d  = ST_DROP;
                else if (vihl_q[3:0] > IPV4_IHL_MIN)  state_d  = ST_OPTIONS;
                else if (csum_sum == CSUM_OK)         hdr_done = 1'b1;
                else                                  state_d  = ST_DROP;
            end
        end

        if (hdr_done) begin
            pay_left_d = pay_len;
            if (pay_len == 16'd0) begin
                irq_d    = 1'b1;
                src_ip_d = src_q;
                state_d  = ST_DROP;
            end else begin
                state_d  = ST_PAYLOAD;
            end
        end
    end

    // prev_q resets high so a frame already in flight across reset is ignored
    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 16'd0;
            pay_left_q <= 16'd0;
            vihl_q     <= 8'd0;
            tl_q       <= 16'd0;
            frag_q     <= 16'd0;
            proto_q    <= 8'd0;
            src_q      <= 32'd0;
            dst_q      <= 24'd0;
            prev_q     <= 1'b1;
            data_q     <= '0;
            data_v_q   <= 1'b0;
            irq_q      <= 1'b0;
            src_ip_q   <= 32'd0;
        end else if (func_en) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pay_left_q <= pay_left_d;
            vihl_q     <= vihl_d;
            tl_q       <= tl_d;
            frag_q     <= frag_d;
            proto_q    <= proto_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            prev_q     <= prev_d;
            data_q     <= data_d;
            data_v_q   <= data_v_d;
            irq_q      <= irq_d;
            src_ip_q   <= src_ip_d;
        end
    end

    assign rx_src_ip      = src_ip_q;
    assign rx_ipv4_irq    = irq_q;
    assign rx_ipv4_data_v = data_v_q;
    assign rx_ipv4_data   = data_q;

endmodule
